// File: rtl/truth_table_sweeper_pkg.sv
// sweeper_pkg: FSM states and counter-width helper for the truth table sweeper.
package sweeper_pkg;
    typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;
    function automatic int dwell_w(input int d);
        return (d > 1) ? $clog2(d) : 1;
    endfunction
endpackage

// File: rtl/truth_table_sweeper_dwell_counter.sv
// dwell_counter: counts 0..DWELL-1 while enabled, wrapping at terminal count.
module dwell_counter #(
    parameter int DWELL = 10,
    parameter int W     = 4
) (
    input  logic clk,
    input  logic rst,
    input  logic clr,
    input  logic en,
    output logic tc
);
    logic [W-1:0] r_cnt;
    assign tc = (r_cnt == W'(DWELL - 1));
    always_ff @(posedge clk) begin
        if (rst || clr) r_cnt <= '0;
        else if (en)    r_cnt <= tc ? '0 : r_cnt + W'(1);
    end
endmodule

// File: rtl/truth_table_sweeper.sv
// truth_table_sweeper: walks every input vector of a combinational DUT,
// holds each for DWELL cycles and compares the settled output against golden.
module truth_table_sweeper
    import sweeper_pkg::*;
#(
    parameter int N_IN  = 4,
    parameter int DWELL = 10
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 start,
    input  logic                 abort,
    input  logic [2**N_IN-1:0]   golden,
    input  logic                 dut_y,
    output logic [N_IN-1:0]      stim,
    output logic                 busy,
    output logic                 done,
    output logic                 pass,
    output logic [N_IN:0]        err_count,
    output logic [N_IN-1:0]      first_fail_idx,
    output logic                 first_fail_valid
);
    localparam int CW = dwell_w(DWELL);
    state_t            r_state;
    logic [N_IN-1:0]   r_stim;
    logic              r_busy;
    logic              r_done;
    logic              r_pass;
    logic [N_IN:0]     r_err;
    logic [N_IN-1:0]   r_ffi;
    logic              r_ffv;
    logic              w_tc;
    logic              w_mis;
    logic [N_IN:0]     w_err;
    dwell_counter #(.DWELL(DWELL), .W(CW)) u_dwell (
        .clk (clk),
        .rst (rst),
        .clr (r_state != RUN || abort),
        .en  (r_state == RUN),
        .tc  (w_tc)
    );
    assign w_mis = dut_y != golden[r_stim];
    assign w_err = r_err + (N_IN+1)'(w_mis);
    // Abort outranks the window-end sample, so a late abort never yields DONE.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= IDLE;
            r_stim  <= '0;
            r_busy  <= 1'b0;
            r_done  <= 1'b0;
            r_pass  <= 1'b0;
            r_err   <= '0;
            r_ffi   <= '0;
            r_ffv   <= 1'b0;
        end else begin
            case (r_state)
                IDLE, DONE: if (start) begin
                    r_state <= RUN;
                    r_stim  <= '0;
                    r_busy  <= 1'b1;
                    r_done  <= 1'b0;
                    r_pass  <= 1'b0;
                    r_err   <= '0;
                    r_ffi   <= '0;
                    r_ffv   <= 1'b0;
                end
                RUN: if (abort) begin
                    r_state <= IDLE;
                    r_stim  <= '0;
                    r_busy  <= 1'b0;
                end else if (w_tc) begin
                    r_err <= w_err;
                    if (w_mis && !r_ffv) begin
                        r_ffi <= r_stim;
                        r_ffv <= 1'b1;
                    end
                    if (r_stim == '1) begin
                        r_state <= DONE;
                        r_busy  <= 1'b0;
                        r_done  <= 1'b1;
                        r_pass  <= (w_err == '0);
                    end else begin
                        r_stim <= r_stim + 1'b1;
                    end
                end
                default: r_state <= IDLE;
            endcase
        end
    end
    assign stim             = r_stim;
    assign busy             = r_busy;
    assign done             = r_done;
    assign pass             = r_pass;
    assign err_count        = r_err;
    assign first_fail_idx   = r_ffi;
    assign first_fail_valid = r_ffv;
endmodule

// File: doc/truth_table_sweeper.md
TRUTH_TABLE_SWEEPER -- requirements
Module: truth_table_sweeper

Interface
REQ-001 SHALL provide parameter N_IN, default 4: number of combinational DUT inputs to sweep; legal range 1..16.
REQ-002 SHALL provide parameter DWELL, default 10: clock cycles each input vector is held; legal range 1..65535.
REQ-003 SHALL use one clock and synchronous, active-high reset; no other clock or reset exists.
REQ-004 clk  input  1  single clock; all state changes on rising edge.
REQ-005 rst  input  1  synchronous active-high reset.
REQ-006 start  input  1  level-sampled request to begin a sweep; honoured only in IDLE or DONE.
REQ-007 abort  input  1  terminate an in-progress sweep.
REQ-008 golden  input  2**N_IN  expected truth table; bit k is the expected output for input vector k.
REQ-009 dut_y  input  1  observed DUT output.
REQ-010 stim  output  N_IN  registered input vector driven to the DUT; bit N_IN-1 is the MSB (first input).
REQ-011 busy  output  1  high while a sweep is in progress.
REQ-012 done  output  1  high while in DONE.
REQ-013 pass  output  1  high in DONE when err_count == 0.
REQ-014 err_count  output  N_IN+1  count of mismatching vectors in the current/last sweep.
REQ-015 first_fail_idx  output  N_IN  index of the first mismatching vector.
REQ-016 first_fail_valid  output  1  first_fail_idx holds a captured value.

Function
REQ-017 SHALL implement FSM states IDLE, RUN, DONE.
REQ-018 IDLE/DONE with start=1 at edge: next cycle -> RUN; stim=0; dwell count=0; err_count, first_fail_valid, first_fail_idx cleared; done=0.
REQ-019 Vector k SHALL be driven for exactly DWELL cycles: cycles 1+k*DWELL .. (k+1)*DWELL after the start edge.
REQ-020 The check SHALL sample dut_y on the last cycle of each window (dwell count == DWELL-1) and compare it to golden[stim].
REQ-021 On mismatch: err_count += 1; if first_fail_valid=0, capture first_fail_idx=stim and set first_fail_valid=1.
REQ-022 On match, err_count and first-fail registers SHALL hold.
REQ-023 After the window for vector 2**N_IN-1: -> DONE, with done=1 first visible at cycle 1+2**N_IN*DWELL after the start edge.
REQ-024 Otherwise at window end: stim += 1 and dwell count = 0; no idle cycle between vectors.
REQ-025 stim SHALL NOT wrap; it holds 2**N_IN-1 in DONE.
REQ-026 err_count SHALL NOT overflow; maximum 2**N_IN fits in N_IN+1 bits.
REQ-027 start while in RUN SHALL be ignored.
REQ-028 abort in RUN SHALL force IDLE next cycle: stim=0, busy=0, done=0, pass=0; err_count and first-fail registers hold for inspection.
REQ-029 If abort and a final-window sample occur in the same cycle, abort SHALL win: no DONE, and the sample is discarded.
REQ-030 abort in IDLE/DONE SHALL have no effect.
REQ-031 If start and abort are both high in IDLE/DONE, start SHALL win.
REQ-032 busy SHALL be 1 exactly in RUN; pass = done AND (err_count == 0).
REQ-033 golden SHALL be sampled live at each compare; the user holds it stable during the sweep.

Reset
REQ-034 rst SHALL take priority over all inputs.
REQ-035 rst SHALL force IDLE with stim=0, busy=0, done=0, pass=0, err_count=0, first_fail_idx=0, first_fail_valid=0, dwell count=0.
REQ-036 rst asserted mid-sweep SHALL discard the sweep, with no partial DONE.

Structure
REQ-037 Package sweeper_pkg SHALL hold the FSM state enum and width constants/functions for the dwell counter width ($clog2 of DWELL, min 1).
REQ-038 Sub-module dwell_counter SHALL provide a parametrised DWELL counter with clear, enable and terminal-count output; it is instantiated once.
REQ-039 The top level SHALL hold the FSM, stim register, compare logic and result registers.

Verification
REQ-040 N_IN=4, DWELL=10, golden=16'h8000 with a correct AND4 DUT model -> done at cycle 161 after start; err_count=0; pass=1; first_fail_valid=0.
REQ-041 Same setup, DUT model forced to 1 for vector 5 -> err_count=1, first_fail_idx=5, first_fail_valid=1, pass=0.
REQ-042 abort during vector 7 -> IDLE next cycle; busy=0, done=0, stim=0; err_count held. Abort on the final-window sample cycle -> no DONE.
REQ-043 rst pulsed during vector 9, then start -> full clean sweep; result equals REQ-040.
REQ-044 DWELL=1, N_IN=2, golden=4'b0110 with an XOR DUT -> stim 0,1,2,3 on consecutive cycles; done at cycle 5; pass=1.
REQ-045 start held high through RUN -> ignored; start in DONE -> restart with counters cleared, and done drops the following cycle.
